// File: rtl/aes_pkg.sv
// Shared AES-128 definitions used by the key schedule and round datapath.
package aes_pkg;

  localparam logic [3:0] NR        = 4'd10;
  localparam logic [7:0] RCON_LAST = 8'h36;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Undoes one GF(2^8) doubling, walking the round constant from 36 back to 01.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    if (r[0]) return ((r ^ 8'h1B) >> 1) | 8'h80;
    else      return r >> 1;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; shared with the encryption path.
module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign subst = SBOX[value];

endmodule

// File: rtl/inv_key_expansion_logic.sv
// Backward AES-128 key schedule: starts from the round-10 key and regenerates
// each earlier round key on demand, one per accepted handshake.
module inv_key_expansion_logic
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_enable,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [3:0]   round_idx,
  output logic         done
);

  state_t       state, state_n;
  logic [7:0]   rcon, rcon_n;
  logic [127:0] key_n;
  logic         valid_n;
  logic [3:0]   idx_n;
  logic         done_n;

  word_t w0, w1, w2, w3;
  word_t p0, p1, p2, p3;
  word_t rot_p3, sub_p3;
  logic  accept;

  assign {w0, w1, w2, w3} = key_out;

  assign p3     = w3 ^ w2;
  assign p2     = w2 ^ w1;
  assign p1     = w1 ^ w0;
  assign rot_p3 = rot_word(p3);

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .value (rot_p3[8*i +: 8]),
      .subst (sub_p3[8*i +: 8])
    );
  end

  // The current round's rcon is what the forward schedule mixed into word 0.
  assign p0 = w0 ^ sub_p3 ^ {rcon, 24'h0};

  assign accept = key_valid && key_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_out   <= '0;
      key_valid <= 1'b0;
      round_idx <= '0;
      done      <= 1'b0;
      rcon      <= '0;
    end else begin
      state     <= state_n;
      key_out   <= key_n;
      key_valid <= valid_n;
      round_idx <= idx_n;
      done      <= done_n;
      rcon      <= rcon_n;
    end
  end

  // A fresh load restarts the walk from any state and suppresses the done pulse.
  always_comb begin
    state_n = state;
    key_n   = key_out;
    valid_n = key_valid;
    idx_n   = round_idx;
    rcon_n  = rcon;
    done_n  = 1'b0;

    if (load_enable) begin
      state_n = ACTIVE;
      key_n   = key_in;
      valid_n = 1'b1;
      idx_n   = NR;
      rcon_n  = RCON_LAST;
    end else begin
      case (state)
        ACTIVE: begin
          if (accept) begin
            if (round_idx != 4'd0) begin
              key_n  = {p0, p1, p2, p3};
              idx_n  = round_idx - 4'd1;
              rcon_n = inv_xtime(rcon);
            end else begin
              state_n = IDLE;
              valid_n = 1'b0;
              done_n  = 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_expansion_logic.sv
// Bench for the backward key schedule: a forward-expansion model fills a
// scoreboard of expected round keys that is drained as the DUT hands them out.
module tb_inv_key_expansion_logic;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk;
  logic         rst;
  logic         load_enable;
  logic [127:0] key_in;
  logic         key_ready;
  logic [127:0] key_out;
  logic         key_valid;
  logic [3:0]   round_idx;
  logic         done;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] rk [0:10];
  logic [131:0] sb [$];

  int checks = 0;
  int passes = 0;

  inv_key_expansion_logic dut (
    .clk         (clk),
    .rst         (rst),
    .load_enable (load_enable),
    .key_in      (key_in),
    .key_ready   (key_ready),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .round_idx   (round_idx),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box built from its algebraic definition: GF inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      b = inv;
      sbox_tab[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_model(input logic [127:0] ck);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]} ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key_in      = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_enable = 1'($urandom_range(0, 1));
      key_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++;
    if (key_valid !== 1'b0 || key_out !== 128'h0 || round_idx !== 4'd0 || done !== 1'b0)
      $display("[TB] FAIL reset_values: got valid=%b key=%h idx=%0d done=%b, want 0/0/0/0",
               key_valid, key_out, round_idx, done);
    else passes++;
    rst = 1'b0; load_enable = 1'b0; key_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (key_valid !== 1'b0 || round_idx !== 4'd0 || done !== 1'b0)
      $display("[TB] FAIL idle_ready_ignored: got valid=%b idx=%0d done=%b, want 0/0/0",
               key_valid, round_idx, done);
    else passes++;
  endtask

  // Full walk from load to done; stall_at >= 0 drops key_ready for 3 cycles there.
  task automatic test_walk(input logic [127:0] ck, input int stall_at);
    logic [131:0] front;
    int budget, stalls, early_done;
    expand_model(ck);
    sb.delete();
    for (int r = 10; r >= 0; r--) sb.push_back({rk[r], 4'(r)});
    @(negedge clk);
    load_enable = 1'b1; key_in = rk[10]; key_ready = 1'b1;
    @(negedge clk);
    load_enable = 1'b0;
    budget = 0; stalls = 0; early_done = 0;
    while (sb.size() > 0 && budget < 60) begin
      budget++;
      if (done) early_done++;
      front = sb[0];
      if (stall_at >= 0 && int'(round_idx) == stall_at && stalls < 3) begin
        key_ready = 1'b0; stalls++;
      end else key_ready = 1'b1;
      checks++;
      if (key_valid !== 1'b1 || key_out !== front[131:4] || round_idx !== front[3:0])
        $display("[TB] FAIL walk_key: got valid=%b key=%h idx=%0d, want valid=1 key=%h idx=%0d",
                 key_valid, key_out, round_idx, front[131:4], front[3:0]);
      else passes++;
      if (key_ready) void'(sb.pop_front());
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0 || early_done != 0)
      $display("[TB] FAIL walk_progress: got %0d keys left, %0d early done pulses, want 0 and 0",
               sb.size(), early_done);
    else passes++;
    checks++;
    if (done !== 1'b1 || key_valid !== 1'b0 || key_out !== rk[0])
      $display("[TB] FAIL walk_done: got done=%b valid=%b key=%h, want done=1 valid=0 key=%h",
               done, key_valid, key_out, rk[0]);
    else passes++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0)
      $display("[TB] FAIL done_single: got done=%b one cycle later, want 0", done);
    else passes++;
  endtask

  task automatic test_fips_walk();
    test_walk(FIPS_KEY, 6);
    checks++;
    if (key_out !== FIPS_KEY || round_idx !== 4'd0)
      $display("[TB] FAIL fips_round0: got key=%h idx=%0d, want key=%h idx=0",
               key_out, round_idx, FIPS_KEY);
    else passes++;
  endtask

  task automatic test_restart();
    logic [127:0] new_ck;
    int budget;
    new_ck = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand_model(FIPS_KEY);
    @(negedge clk);
    load_enable = 1'b1; key_in = rk[10]; key_ready = 1'b1;
    @(negedge clk);
    load_enable = 1'b0;
    budget = 0;
    while (round_idx !== 4'd4 && budget < 40) begin
      @(negedge clk); budget++;
    end
    checks++;
    if (round_idx !== 4'd4)
      $display("[TB] FAIL restart_reach: got idx=%0d, want 4", round_idx);
    else passes++;
    expand_model(new_ck);
    load_enable = 1'b1; key_in = rk[10];
    @(negedge clk);
    load_enable = 1'b0;
    checks++;
    if (key_valid !== 1'b1 || round_idx !== 4'd10 || key_out !== rk[10] || done !== 1'b0)
      $display("[TB] FAIL restart_load: got valid=%b idx=%0d key=%h done=%b, want 1/10/%h/0",
               key_valid, round_idx, key_out, done, rk[10]);
    else passes++;
    @(negedge clk);
    checks++;
    if (round_idx !== 4'd9 || key_out !== rk[9] || done !== 1'b0)
      $display("[TB] FAIL restart_rcon: got idx=%0d key=%h done=%b, want 9/%h/0",
               round_idx, key_out, done, rk[9]);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_walk();
    int budget;
    expand_model(FIPS_KEY);
    @(negedge clk);
    load_enable = 1'b1; key_in = rk[10]; key_ready = 1'b1;
    @(negedge clk);
    load_enable = 1'b0;
    budget = 0;
    while (round_idx !== 4'd7 && budget < 40) begin
      @(negedge clk); budget++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (key_valid !== 1'b0 || key_out !== 128'h0 || round_idx !== 4'd0 || done !== 1'b0)
      $display("[TB] FAIL reset_mid: got valid=%b key=%h idx=%0d done=%b, want 0/0/0/0",
               key_valid, key_out, round_idx, done);
    else passes++;
    test_walk({$urandom(), $urandom(), $urandom(), $urandom()}, -1);
  endtask

  task automatic test_round_trip();
    for (int k = 0; k < 100; k++)
      test_walk({$urandom(), $urandom(), $urandom(), $urandom()}, $urandom_range(0, 10));
  endtask

  initial begin
    rst = 1'b1; load_enable = 1'b0; key_in = '0; key_ready = 1'b0;
    build_sbox();
    test_reset();
    test_fips_walk();
    test_restart();
    test_reset_mid_walk();
    test_round_trip();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
